// File: rtl/controller.sv
// Successive-approximation conversion controller: samples on go, resolves one bit per
// cycle from MSB to LSB against an external comparator, then presents the result.
module controller (
  input  logic       clk,
  input  logic       go,
  output logic       valid,
  output logic [7:0] result,
  output logic       sample,
  output logic [7:0] value,
  input  logic       cmp,
  input  logic       rst
);

  typedef enum logic [1:0] {
    WAIT   = 2'b00,
    SAMPLE = 2'b01,
    CONV   = 2'b10,
    DONE   = 2'b11
  } state_t;

  state_t     state;
  logic [7:0] mask;

  // Status strobes and the trial code are pure decodes of registered state, so cmp
  // answers for the code presented in this very cycle.
  assign sample = (state == SAMPLE);
  assign valid  = (state == DONE);
  assign value  = result | mask;

  // Conversion sequencer: mask walks one bit right per CONV cycle; hitting bit 0 ends it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= WAIT;
      result <= 8'h00;
      mask   <= 8'h00;
    end else begin
      case (state)
        WAIT: begin
          if (go) begin
            state <= SAMPLE;
          end else begin
            state <= WAIT;
          end
        end
        SAMPLE: begin
          result <= 8'h00;
          mask   <= 8'h80;
          state  <= CONV;
        end
        CONV: begin
          if (cmp) begin
            result <= result | mask;
          end else begin
            result <= result;
          end
          mask <= {1'b0, mask[7:1]};
          if (mask == 8'h01) begin
            state <= DONE;
          end else begin
            state <= CONV;
          end
        end
        DONE: begin
          if (go) begin
            state <= DONE;
          end else begin
            state <= WAIT;
          end
        end
        default: begin
          state <= WAIT;
          mask  <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controller.sv
// Directed self-checking bench for the successive-approximation controller; the
// comparator is modelled in the bench against a fixed analog target.
module tb_controller;

  logic       clk;
  logic       go;
  logic       valid;
  logic [7:0] result;
  logic       sample;
  logic [7:0] value;
  logic       cmp;
  logic       rst;

  logic [1:0] mode;    // 0: compare against target, 1: always 1, 2: always 0
  logic [7:0] target;

  int checks;
  int errors;

  controller dut (
    .clk    (clk),
    .go     (go),
    .valid  (valid),
    .result (result),
    .sample (sample),
    .value  (value),
    .cmp    (cmp),
    .rst    (rst)
  );

  assign cmp = (mode == 2'd0) ? (target >= value) : (mode == 2'd1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drives go high for go_len cycles; n is the number of edges until valid rises
  // (counted from the first edge that samples go), capped at 30.
  task automatic run_to_valid(input int go_len, output int n);
    go = 1'b1;
    n  = 0;
    while (!valid && n < 30) begin
      tick();
      n++;
      if (n == go_len) go = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; go = 1'b0; mode = 2'd0; target = 8'h46;
    tick(); tick();
    checks++;
    if (dut.state !== 2'b00 || dut.mask !== 8'h00 || result !== 8'h00 ||
        valid !== 1'b0 || sample !== 1'b0 || value !== 8'h00) begin
      errors++;
      $display("FAIL reset: state=%b mask=%h result=%h valid=%b sample=%b value=%h, need 00/00/00/0/0/00",
               dut.state, dut.mask, result, valid, sample, value);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    logic [7:0] seq [8];
    seq = '{8'h80, 8'h40, 8'h60, 8'h50, 8'h48, 8'h44, 8'h46, 8'h47};
    mode = 2'd0; target = 8'h46;
    go = 1'b1;
    tick();
    checks++;
    if (sample !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_sample: sample=%b valid=%b, need 1/0", sample, valid);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (value !== seq[i] || sample !== 1'b0 || valid !== 1'b0) begin
        errors++;
        $display("FAIL basic_value[%0d]: value=%h sample=%b valid=%b, need %h/0/0",
                 i, value, sample, valid, seq[i]);
      end
    end
    tick();
    checks++;
    if (valid !== 1'b1 || result !== 8'h46 || dut.mask !== 8'h00) begin
      errors++;
      $display("FAIL basic_done: valid=%b result=%h mask=%h, need 1/46/00", valid, result, dut.mask);
    end
  endtask

  task automatic test_hold_done;
    int bad;
    bad = 0;
    go = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (valid !== 1'b1 || result !== 8'h46 || value !== 8'h46 || sample !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_done: %0d bad cycles, need 0 (valid=%b result=%h value=%h sample=%b)",
               bad, valid, result, value, sample);
    end
  endtask

  task automatic test_restart;
    int n;
    go = 1'b0;
    tick();
    checks++;
    if (dut.state !== 2'b00 || valid !== 1'b0 || result !== 8'h46 || value !== 8'h46) begin
      errors++;
      $display("FAIL restart_wait: state=%b valid=%b result=%h value=%h, need 00/0/46/46",
               dut.state, valid, result, value);
    end
    tick(); tick();
    checks++;
    if (result !== 8'h46 || sample !== 1'b0) begin
      errors++;
      $display("FAIL restart_stable: result=%h sample=%b, need 46/0", result, sample);
    end
    go = 1'b1;
    tick();
    checks++;
    if (sample !== 1'b1) begin
      errors++;
      $display("FAIL restart_sample: sample=%b, need 1", sample);
    end
    tick();
    checks++;
    if (result !== 8'h00 || value !== 8'h80) begin
      errors++;
      $display("FAIL restart_clear: result=%h value=%h, need 00/80", result, value);
    end
    n = 2;
    while (!valid && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (n != 10 || result !== 8'h46) begin
      errors++;
      $display("FAIL restart_conv: latency=%0d result=%h, need 10/46", n, result);
    end
    go = 1'b0;
    tick();
  endtask

  task automatic test_short_go;
    int n;
    mode = 2'd0; target = 8'h46;
    run_to_valid(2, n);
    checks++;
    if (n != 10 || result !== 8'h46) begin
      errors++;
      $display("FAIL short_go: latency=%0d result=%h, need 10/46", n, result);
    end
    tick();
    checks++;
    if (valid !== 1'b0 || dut.state !== 2'b00 || result !== 8'h46) begin
      errors++;
      $display("FAIL short_go_wait: valid=%b state=%b result=%h, need 0/00/46", valid, dut.state, result);
    end
  endtask

  task automatic test_extremes;
    int n;
    mode = 2'd1;
    run_to_valid(1, n);
    checks++;
    if (n != 10 || result !== 8'hFF) begin
      errors++;
      $display("FAIL extreme_ones: latency=%0d result=%h, need 10/ff", n, result);
    end
    tick();
    mode = 2'd2;
    run_to_valid(1, n);
    checks++;
    if (n != 10 || result !== 8'h00) begin
      errors++;
      $display("FAIL extreme_zeros: latency=%0d result=%h, need 10/00", n, result);
    end
    tick();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL extreme_pulse: valid=%b, need 0", valid);
    end
  endtask

  task automatic test_mid_reset;
    int n;
    int bad;
    mode = 2'd0; target = 8'h46;
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (dut.state !== 2'b10 || dut.mask !== 8'h10) begin
      errors++;
      $display("FAIL mid_setup: state=%b mask=%h, need 10/10", dut.state, dut.mask);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (valid !== 1'b0 || sample !== 1'b0 || result !== 8'h00 || value !== 8'h00 ||
        dut.state !== 2'b00 || dut.mask !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset: valid=%b sample=%b result=%h value=%h state=%b mask=%h, need 0/0/00/00/00/00",
               valid, sample, result, value, dut.state, dut.mask);
    end
    #1;
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (dut.state !== 2'b00 || sample !== 1'b0 || value !== 8'h00) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_idle: %0d bad cycles, need 0", bad);
    end
    run_to_valid(1, n);
    checks++;
    if (n != 10 || result !== 8'h46) begin
      errors++;
      $display("FAIL mid_fresh: latency=%0d result=%h, need 10/46", n, result);
    end
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_hold_done();
    test_restart();
    test_short_go();
    test_extremes();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
